// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and sequencer state encoding
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int REG_N  = 4;

    typedef logic [DATA_W-1:0] data_t;

    // ALU opcodes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_INC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_EXEC  = 2'b10;
    localparam logic [1:0] ST_WB    = 2'b11;

endpackage

// File: rtl/alu_ctrl_alu.sv
// rtl/alu_ctrl_alu.sv - combinational 8-bit ALU datapath (x op bus -> dout)
module alu
    import alu_pkg::*;
(
    input  logic [2:0] alus,
    input  data_t      x,
    input  data_t      bus,
    output data_t      dout
);

    // Pure datapath; unary ops ignore bus, all arithmetic wraps modulo 256
    always_comb begin
        dout = '0;
        case (alus)
            OP_ADD:  dout = x + bus;
            OP_INC:  dout = x + 8'd1;
            OP_SUB:  dout = x - bus;
            OP_DEC:  dout = x - 8'd1;
            OP_AND:  dout = x & bus;
            OP_OR:   dout = x | bus;
            OP_NOT:  dout = ~x;
            OP_SHL:  dout = {x[DATA_W-2:0], 1'b0};
            default: dout = '0;
        endcase
    end

endmodule

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - four-cycle command sequencer owning the register file, ALU and flags
module alu_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [1:0]  cmd_rs,
    input  logic [1:0]  cmd_rd,
    input  logic        ld_valid,
    input  logic [1:0]  ld_sel,
    input  logic [7:0]  ld_data,
    input  logic [1:0]  rd_sel,
    output logic [7:0]  rd_data,
    output logic        done,
    output logic [7:0]  result,
    output logic        zf,
    output logic        cf
);

    logic [1:0] state_q;
    logic [2:0] op_q;
    logic [1:0] rs_q;
    logic [1:0] rd_q;
    data_t      x_q;
    data_t      b_q;
    data_t      res_q;
    logic       carry_q;
    data_t      regs [REG_N];
    data_t      result_q;
    logic       zf_q;
    logic       cf_q;

    data_t      alu_dout;
    logic       carry_c;
    logic [8:0] sum9;
    logic [8:0] diff9;

    alu u_alu (
        .alus (op_q),
        .x    (x_q),
        .bus  (b_q),
        .dout (alu_dout)
    );

    // Carry/borrow from a 9-bit evaluation of the latched operands
    always_comb begin
        sum9    = {1'b0, x_q} + {1'b0, b_q};
        diff9   = {1'b0, x_q} - {1'b0, b_q};
        carry_c = 1'b0;
        case (op_q)
            OP_ADD:  carry_c = sum9[8];
            OP_SUB:  carry_c = diff9[8];
            OP_INC:  carry_c = (x_q == 8'hFF);
            OP_DEC:  carry_c = (x_q == 8'h00);
            OP_SHL:  carry_c = x_q[7];
            default: carry_c = 1'b0;
        endcase
    end

    // Loads take priority over commands; nothing is accepted outside IDLE
    always_comb begin
        cmd_ready = !rst && !ld_valid && (state_q == ST_IDLE);
    end

    // Writeback pulse; suppressed when reset aborts the operation
    always_comb begin
        done = (state_q == ST_WB) && !rst;
    end

    // Observation port and architectural outputs
    always_comb begin
        rd_data = regs[rd_sel];
        result  = result_q;
        zf      = zf_q;
        cf      = cf_q;
    end

    // IDLE -> FETCH -> EXEC -> WB sequencer with register file and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            rs_q     <= '0;
            rd_q     <= '0;
            x_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ld_valid) begin
                        regs[ld_sel] <= ld_data;
                    end else if (cmd_valid) begin
                        op_q    <= cmd_op;
                        rs_q    <= cmd_rs;
                        rd_q    <= cmd_rd;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    x_q     <= regs[rs_q];
                    b_q     <= regs[rd_q];
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q   <= alu_dout;
                    carry_q <= carry_c;
                    state_q <= ST_WB;
                end
                ST_WB: begin
                    regs[rd_q] <= res_q;
                    result_q   <= res_q;
                    zf_q       <= (res_q == 8'h00);
                    cf_q       <= carry_q;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - directed and randomized self-checking bench for alu_ctrl
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [1:0] cmd_rs = '0;
    logic [1:0] cmd_rd = '0;
    logic       ld_valid = 1'b0;
    logic [1:0] ld_sel = '0;
    logic [7:0] ld_data = '0;
    logic [1:0] rd_sel = '0;
    logic [7:0] rd_data;
    logic       done;
    logic [7:0] result;
    logic       zf;
    logic       cf;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int prev_acc = 0;
    bit prev_kept = 1'b0;

    logic [7:0] m_reg [4];
    logic [7:0] m_result;
    logic       m_zf;
    logic       m_cf;

    alu_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rs    (cmd_rs),
        .cmd_rd    (cmd_rd),
        .ld_valid  (ld_valid),
        .ld_sel    (ld_sel),
        .ld_data   (ld_data),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .done      (done),
        .result    (result),
        .zf        (zf),
        .cf        (cf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {carry, result} from arithmetic on integers
    function automatic logic [8:0] ref_op(input logic [2:0] op, input int x, input int b);
        int v;
        bit c;
        v = 0;
        c = 1'b0;
        case (op)
            3'd0: begin v = x + b;   c = (v > 255);  end
            3'd1: begin v = x + 1;   c = (x == 255); end
            3'd2: begin v = x - b;   c = (x < b);    end
            3'd3: begin v = x - 1;   c = (x == 0);   end
            3'd4: begin v = x & b;   c = 1'b0;       end
            3'd5: begin v = x | b;   c = 1'b0;       end
            3'd6: begin v = 255 - x; c = 1'b0;       end
            default: begin v = x * 2; c = (x >= 128); end
        endcase
        return {c, 8'(v & 255)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_result = 8'h00;
        m_zf = 1'b0;
        m_cf = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_result"}, result, m_result);
        chk({tag, "_zf"}, zf, m_zf);
        chk({tag, "_cf"}, cf, m_cf);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), rd_data, m_reg[i]);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        rd_sel = idx;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic load(input logic [1:0] sel, input logic [7:0] data);
        ld_valid = 1'b1;
        ld_sel = sel;
        ld_data = data;
        #1;
        chk("ld_blocks_ready", cmd_ready, 1'b0);
        tick();
        ld_valid = 1'b0;
        m_reg[sel] = data;
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rd,
                          input bit keep, input bit ld_exec);
        logic [8:0] r;
        int n;
        cmd_op = op;
        cmd_rs = rs;
        cmd_rd = rd;
        cmd_valid = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready && n < 8) begin
            tick();
            n++;
        end
        chk("accept_ready", cmd_ready, 1'b1);
        r = ref_op(op, int'(m_reg[rs]), int'(m_reg[rd]));
        tick();
        if (prev_kept) chk("accept_gap", cyc - prev_acc, 4);
        prev_acc = cyc;
        prev_kept = keep;
        if (!keep) cmd_valid = 1'b0;
        chk("fetch_ready", cmd_ready, 1'b0);
        chk("fetch_done", done, 1'b0);
        tick();
        chk("exec_ready", cmd_ready, 1'b0);
        if (ld_exec) begin
            ld_valid = 1'b1;
            ld_sel = rs;
            ld_data = m_reg[rs] ^ 8'h5A;
        end
        tick();
        ld_valid = 1'b0;
        chk("wb_done", done, 1'b1);
        chk("wb_ready", cmd_ready, 1'b0);
        tick();
        m_reg[rd] = r[7:0];
        m_result = r[7:0];
        m_zf = (r[7:0] == 8'h00);
        m_cf = r[8];
        chk("post_done", done, 1'b0);
        chk("post_ready", cmd_ready, 1'b1);
        check_state("post");
    endtask

    initial begin
        model_reset();
        tick();
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_done", done, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("rel_ready", cmd_ready, 1'b1);
        chk("rel_done", done, 1'b0);
        check_state("reset");

        // ADD
        load(2'd0, 8'h05);
        load(2'd1, 8'h03);
        do_cmd(3'b000, 2'd0, 2'd1, 1'b0, 1'b0);
        rd_chk("add_r1", 2'd1, 8'h08);
        chk("add_zf", zf, 1'b0);
        chk("add_cf", cf, 1'b0);

        // INC wrap
        load(2'd2, 8'hFF);
        do_cmd(3'b001, 2'd2, 2'd2, 1'b0, 1'b0);
        rd_chk("inc_r2", 2'd2, 8'h00);
        chk("inc_zf", zf, 1'b1);
        chk("inc_cf", cf, 1'b1);

        // SUB borrow then SHL
        load(2'd0, 8'h03);
        load(2'd1, 8'h05);
        do_cmd(3'b010, 2'd0, 2'd1, 1'b0, 1'b0);
        rd_chk("sub_r1", 2'd1, 8'hFE);
        chk("sub_cf", cf, 1'b1);
        do_cmd(3'b111, 2'd1, 2'd3, 1'b0, 1'b0);
        rd_chk("shl_r3", 2'd3, 8'hFC);
        chk("shl_cf", cf, 1'b1);

        // Load and command in the same IDLE cycle
        cmd_op = 3'b110;
        cmd_rs = 2'd0;
        cmd_rd = 2'd2;
        cmd_valid = 1'b1;
        ld_valid = 1'b1;
        ld_sel = 2'd0;
        ld_data = 8'hAA;
        #1;
        chk("tie_ready", cmd_ready, 1'b0);
        tick();
        ld_valid = 1'b0;
        m_reg[0] = 8'hAA;
        #1;
        chk("tie_held_ready", cmd_ready, 1'b1);
        chk("tie_no_done", done, 1'b0);
        do_cmd(3'b110, 2'd0, 2'd2, 1'b0, 1'b0);
        rd_chk("not_r2", 2'd2, 8'h55);

        // Back-to-back with cmd_valid held; ld pulse during EXEC ignored
        do_cmd(3'b000, 2'd0, 2'd1, 1'b1, 1'b1);
        do_cmd(3'b101, 2'd3, 2'd0, 1'b1, 1'b1);
        do_cmd(3'b100, 2'd2, 2'd3, 1'b0, 1'b0);
        prev_kept = 1'b0;

        // Randomized commands and loads
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) load(2'($urandom_range(0, 3)), 8'($urandom));
            do_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   1'b0, 1'($urandom_range(0, 1)));
        end

        // Reset during EXEC of an ADD
        load(2'd0, 8'h81);
        load(2'd1, 8'h90);
        cmd_op = 3'b000;
        cmd_rs = 2'd0;
        cmd_rd = 2'd1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("abort_exec_done", done, 1'b0);
        tick();
        chk("abort_wb_done", done, 1'b0);
        chk("abort_ready", cmd_ready, 1'b0);
        tick();
        rst = 1'b0;
        model_reset();
        #1;
        chk("abort_rel_ready", cmd_ready, 1'b1);
        chk("abort_rel_done", done, 1'b0);
        check_state("abort");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
